demorgan_sweep: RTL and testbench

- Sequential stimulus-and-check stage that sits directly upstream of the two-input De Morgan gate block.
- Drives its A/B inputs through all four combinations and samples the eight returned outputs after a configurable settle time.
- Compares each output against the expected truth-table value and reports per-vector pass/fail plus a mismatch count.
- Replaces hand-stepped #delay stimulus with a clocked sweep usable both on-chip and in benches.

---
 rtl/demorgan_sweep.sv | 215 +++++++++++++++++++++
 tb/tb_demorgan_sweep.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demorgan_sweep.sv
// -----------------------------------------------------------------------------
// demorgan_sweep
//
// Clocked stimulus-and-check stage for a two-input De Morgan gate block.
// A start pulse walks {A,B} through 00, 01, 10, 11. Each vector is held for
// SETTLE_CYCLES cycles, and then the eight returned gate outputs are compared
// for one cycle against their truth-table values. The stage reports which
// vectors failed and how many output bits mismatched in total. The total
// saturates at 2^ERR_W-1.
//
// Parameters
//   SETTLE_CYCLES : cycles a vector is held before it is checked (1..15)
//   ERR_W         : width of the saturating mismatch-bit counter
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset, priority over everything
//   start      in   one-cycle sweep request (ignored while busy)
//   A, B       out  registered stimulus to the gate block
//   nA .. nAB  in   the eight gate-block outputs under test
//   busy       out  sweep in progress (SETTLE or CHECK)
//   done       out  sweep finished, results held (level)
//   pass       out  valid with done; 1 = no mismatching bit anywhere
//   fail_vec   out  bit k set if vector {A,B}=k had any mismatch
//   err_count  out  saturating total of mismatching output bits
//   vec_idx    out  index of the vector currently applied
// -----------------------------------------------------------------------------
module demorgan_sweep #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             A,
  output logic             B,
  input  logic             nA,
  input  logic             nB,
  input  logic             AB,
  input  logic             AorB,
  input  logic             nAandnB,
  input  logic             nAorB,
  input  logic             nAornB,
  input  logic             nAB,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_vec,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // The settle counter counts down to zero. Loading SETTLE_CYCLES-1 therefore
  // gives exactly SETTLE_CYCLES cycles in SETTLE.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  // The sum is widened so that adding up to 8 to a saturated count cannot wrap.
  localparam int              SUM_W   = ERR_W + 4;
  localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'({ERR_W{1'b1}});

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic               a_q;
  logic               b_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [3:0]         fail_vec_q;
  logic [ERR_W-1:0]   err_count_q;
  logic [1:0]         vec_idx_q;

  // Combinational compare results for the vector currently applied.
  logic [7:0]         expect_d;
  logic [7:0]         sample_d;
  logic [7:0]         mismatch_d;
  logic [3:0]         mm_cnt_d;
  logic               mm_any_d;
  logic [SUM_W-1:0]   err_sum_d;
  logic [ERR_W-1:0]   err_count_d;

  // The bit order is the same in expect_d and sample_d:
  // {nA, nB, AB, AorB, nAandnB, nAorB, nAornB, nAB}
  assign expect_d = {
    ~a_q,
    ~b_q,
    a_q & b_q,
    a_q | b_q,
    ~a_q & ~b_q,
    ~(a_q | b_q),
    ~a_q | ~b_q,
    ~(a_q & b_q)
  };

  assign sample_d = {nA, nB, AB, AorB, nAandnB, nAorB, nAornB, nAB};

  // Each bit is compared with an if/else instead of XOR. If a sampled bit is
  // X or Z, the equality is not true, so the else branch flags a mismatch.
  // An X value does not propagate into the count.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bitcmp
      logic bit_mm;
      always_comb begin
        if (sample_d[gi] == expect_d[gi]) begin
          bit_mm = 1'b0;
        end else begin
          bit_mm = 1'b1;
        end
      end
      assign mismatch_d[gi] = bit_mm;
    end
  endgenerate

  always_comb begin
    mm_cnt_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      mm_cnt_d = mm_cnt_d + 4'(mismatch_d[i]);
    end
  end

  assign mm_any_d  = |mismatch_d;
  assign err_sum_d = SUM_W'(err_count_q) + SUM_W'(mm_cnt_d);

  always_comb begin
    if (err_sum_d > ERR_MAX) begin
      err_count_d = {ERR_W{1'b1}};
    end else begin
      err_count_d = err_sum_d[ERR_W-1:0];
    end
  end

  // Sweep controller. All outputs are registered here, so A and B change
  // only on edges that enter SETTLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= 4'd0;
      err_count_q <= '0;
      vec_idx_q   <= 2'd0;
    end else begin
      case (state_q)
        // A new sweep can be launched from IDLE or DONE. The previous
        // results are cleared on the same edge that launches it.
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_SETTLE;
            cnt_q       <= CNT_LOAD;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_vec_q  <= 4'd0;
            err_count_q <= '0;
            vec_idx_q   <= 2'd0;
          end
        end

        S_SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_CHECK: begin
          err_count_q           <= err_count_d;
          fail_vec_q[vec_idx_q] <= mm_any_d;
          if (vec_idx_q != 2'd3) begin
            // Apply the next vector. A is the MSB of the vector index.
            vec_idx_q  <= vec_idx_q + 2'd1;
            {a_q, b_q} <= vec_idx_q + 2'd1;
            cnt_q      <= CNT_LOAD;
            state_q    <= S_SETTLE;
          end else begin
            // fail_vec_q[3] is still clear from the launch. The current
            // mismatch is checked directly so that pass reflects all four
            // vectors.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_vec_q == 4'd0) && !mm_any_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_vec  = fail_vec_q;
  assign err_count = err_count_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_demorgan_sweep.sv
// -----------------------------------------------------------------------------
// tb_demorgan_sweep
//
// This bench drives two sweepers:
//   - dut1 uses SETTLE_CYCLES=1 and ERR_W=6. Its gate-block model can switch
//     between a correct mode and several faulty modes.
//   - dut3 uses SETTLE_CYCLES=3 and ERR_W=3. Its gate block has every output
//     inverted.
// The stimulus process pushes hand-computed expected results into a queue for
// each sweep it launches. A separate monitor per DUT pops an entry when done
// rises and compares the results. While a sweep is active, the monitor also
// checks the A/B sequence on every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demorgan_sweep;

  localparam int S1 = 1;
  localparam int E1 = 6;
  localparam int S3 = 3;
  localparam int E3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start1;
  logic          start3;
  int            mode1;

  logic          a1, b1, busy1, done1, pass1;
  logic [3:0]    fv1;
  logic [E1-1:0] err1;
  logic [1:0]    vi1;
  logic [7:0]    g1;

  logic          a3, b3, busy3, done3, pass3;
  logic [3:0]    fv3;
  logic [E3-1:0] err3;
  logic [1:0]    vi3;
  logic [7:0]    g3;

  // Gate-block model. Output order is
  // {nA, nB, AB, AorB, nAandnB, nAorB, nAornB, nAB}.
  // Modes: 0 correct, 1 nAB stuck at 1, 2 AB/AorB swapped, 3 all inverted.
  function automatic logic [7:0] gate(input logic a, input logic b, input int mode);
    logic [7:0] o;
    o = {~a, ~b, a & b, a | b, ~a & ~b, ~(a | b), ~a | ~b, ~(a & b)};
    case (mode)
      1: o[0] = 1'b1;
      2: begin o[5] = a | b; o[4] = a & b; end
      3: o = ~o;
      default: ;
    endcase
    return o;
  endfunction

  assign g1 = gate(a1, b1, mode1);
  assign g3 = gate(a3, b3, 3);

  demorgan_sweep #(.SETTLE_CYCLES(S1), .ERR_W(E1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
    .nA(g1[7]), .nB(g1[6]), .AB(g1[5]), .AorB(g1[4]),
    .nAandnB(g1[3]), .nAorB(g1[2]), .nAornB(g1[1]), .nAB(g1[0]),
    .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fv1),
    .err_count(err1), .vec_idx(vi1)
  );

  demorgan_sweep #(.SETTLE_CYCLES(S3), .ERR_W(E3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .A(a3), .B(b3),
    .nA(g3[7]), .nB(g3[6]), .AB(g3[5]), .AorB(g3[4]),
    .nAandnB(g3[3]), .nAorB(g3[2]), .nAornB(g3[1]), .nAB(g3[0]),
    .busy(busy3), .done(done3), .pass(pass3), .fail_vec(fv3),
    .err_count(err3), .vec_idx(vi3)
  );

  typedef struct {
    int         start_edge;
    int         done_edge;
    logic [3:0] fv;
    int         err;
    logic       pass;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp_v, edge_cnt);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : mon1
    logic dprev;
    int   r;
    exp_t e;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      chk("dut1_busy_done_excl", int'(busy1 & done1), 0);
      chk("dut1_pass_only_with_done", int'(pass1 & ~done1), 0);
      if (q1.size() > 0 && edge_cnt >= q1[0].start_edge && edge_cnt < q1[0].done_edge) begin
        r = edge_cnt - q1[0].start_edge;
        chk("dut1_ab_seq", int'({a1, b1}), r / (S1 + 1));
        chk("dut1_busy_in_sweep", int'(busy1), 1);
      end
      if (done1 && !dprev) begin
        if (q1.size() == 0) begin
          chk("dut1_spurious_done", 1, 0);
        end else begin
          e = q1.pop_front();
          $display("dut1 sweep: fail_vec=%b err=%0d pass=%0d at edge %0d", fv1, err1, pass1, edge_cnt);
          chk("dut1_latency", edge_cnt, e.done_edge);
          chk("dut1_fail_vec", int'(fv1), int'(e.fv));
          chk("dut1_err_count", int'(err1), e.err);
          chk("dut1_pass", int'(pass1), int'(e.pass));
          chk("dut1_ab_final", int'({a1, b1}), 3);
          chk("dut1_vec_idx_final", int'(vi1), 3);
          chk("dut1_busy_at_done", int'(busy1), 0);
        end
      end
      dprev = done1;
    end
  end

  initial begin : mon3
    logic dprev;
    exp_t e;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      chk("dut3_busy_done_excl", int'(busy3 & done3), 0);
      if (done3 && !dprev) begin
        if (q3.size() == 0) begin
          chk("dut3_spurious_done", 1, 0);
        end else begin
          e = q3.pop_front();
          $display("dut3 sweep: fail_vec=%b err=%0d pass=%0d at edge %0d", fv3, err3, pass3, edge_cnt);
          chk("dut3_latency", edge_cnt, e.done_edge);
          chk("dut3_fail_vec", int'(fv3), int'(e.fv));
          chk("dut3_err_count", int'(err3), e.err);
          chk("dut3_pass", int'(pass3), int'(e.pass));
          chk("dut3_ab_final", int'({a3, b3}), 3);
        end
      end
      dprev = done3;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int which, input int budget);
    int n;
    n = 0;
    while (!((which == 1) ? done1 : done3) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!((which == 1) ? done1 : done3)) begin
      n_vec++;
      n_err++;
      $display("FAIL dut%0d_wait_done: done=0 after %0d cycles, required done=1", which, n);
    end
  endtask

  // Launches a dut1 sweep from the current negedge and queues its expected
  // result. If extra is set, start is also pulsed at sweep edges 2 and 5.
  // Those pulses must be ignored.
  task automatic run1(input int m, input logic [3:0] fv, input int err, input logic p,
                      input logic extra);
    exp_t e;
    mode1        = m;
    e.start_edge = edge_cnt + 1;
    e.done_edge  = edge_cnt + 1 + 4 * (S1 + 1);
    e.fv         = fv;
    e.err        = err;
    e.pass       = p;
    q1.push_back(e);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    if (extra) begin
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
    end
    wait_done(1, 40);
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_busy"}, int'(busy1), 0);
    chk({tag, "_done"}, int'(done1), 0);
    chk({tag, "_pass"}, int'(pass1), 0);
    chk({tag, "_ab"}, int'({a1, b1}), 0);
    chk({tag, "_fail_vec"}, int'(fv1), 0);
    chk({tag, "_err"}, int'(err1), 0);
    chk({tag, "_vec_idx"}, int'(vi1), 0);
  endtask

  initial begin : stim
    exp_t e3;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    mode1  = 0;
    repeat (2) @(negedge clk);
    chk_reset1("reset1");
    chk("reset3_busy", int'(busy3), 0);
    chk("reset3_done", int'(done3), 0);
    chk("reset3_err", int'(err3), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run1(0, 4'b0000, 0, 1'b1, 1'b0);   // correct gate block, launched from IDLE
    run1(1, 4'b1000, 1, 1'b0, 1'b0);   // nAB stuck at 1
    run1(2, 4'b0110, 4, 1'b0, 1'b0);   // AB/AorB swapped
    run1(3, 4'b1111, 32, 1'b0, 1'b0);  // everything inverted: 32 fits in 6 bits
    run1(0, 4'b0000, 0, 1'b1, 1'b1);   // start pulses while busy are ignored
    run1(0, 4'b0000, 0, 1'b1, 1'b0);   // restart in DONE repeats the sweep

    // Abort a faulty sweep with reset during the vector-2 SETTLE phase.
    // This sweep is not queued because it never completes.
    mode1  = 2;
    start1 = 1'b1;
    @(negedge clk);                    // after start edge s
    start1 = 1'b0;
    repeat (4) @(negedge clk);         // after edge s+4: vector 2 SETTLE
    chk("abort_vec_idx", int'(vi1), 2);
    chk("abort_err_before_reset", int'(err1), 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset1("abort");
    run1(0, 4'b0000, 0, 1'b1, 1'b0);   // clean sweep after the abort

    // Counter saturation and longer settle time on dut3.
    e3.start_edge = edge_cnt + 1;
    e3.done_edge  = edge_cnt + 1 + 4 * (S3 + 1);
    e3.fv         = 4'b1111;
    e3.err        = 7;
    e3.pass       = 1'b0;
    q3.push_back(e3);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_done(3, 60);

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Overall bound in case something stalls outside wait_done.
  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
